// File: rtl/store_unit.sv
// Two-entry store buffer: captures STORE dispatches, waits for operands on the
// result broadcast, then writes to memory one entry at a time in dispatch order.
module store_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [39:0]  instbus1,
    input  logic [39:0]  instbus2,
    input  logic [127:0] regfile,
    input  logic         cdb_valid,
    input  logic [39:0]  cdb,
    input  logic         mem_ready,
    output logic         mem_wr_en,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_data,
    output logic [1:0]   busy,
    output logic         dispatch_err
);

    localparam int unsigned N_ENT  = 2;
    localparam int unsigned N_BUS  = 2;
    localparam int unsigned N_REG  = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 8;

    localparam logic [TAG_W-1:0] OP_STORE = 8'h02;
    localparam logic [TAG_W-1:0] TAG_ST0  = 8'h50;
    localparam logic [TAG_W-1:0] TAG_ST1  = 8'h51;
    localparam logic [5:0]       REG_BASE = 6'h04;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_WRITE = 2'd3
    } ent_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  unit;
        logic [TAG_W-1:0]  opcode;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  src;
    } inst_t;

    ent_state_t        r_state [N_ENT];
    logic [ADDR_W-1:0] r_addr  [N_ENT];
    logic [DATA_W-1:0] r_data  [N_ENT];
    logic [TAG_W-1:0]  r_tag   [N_ENT];
    logic              r_older;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [N_ENT-1:0]  r_busy;
    logic              r_err;

    ent_state_t        w_state_nx [N_ENT];
    logic [ADDR_W-1:0] w_addr_nx  [N_ENT];
    logic [DATA_W-1:0] w_data_nx  [N_ENT];
    logic [TAG_W-1:0]  w_tag_nx   [N_ENT];
    logic              w_older_nx;
    logic              w_mem_wr_en_nx;
    logic [ADDR_W-1:0] w_mem_addr_nx;
    logic [DATA_W-1:0] w_mem_data_nx;
    logic [N_ENT-1:0]  w_busy_nx;
    logic              w_err_nx;

    inst_t             w_inst  [N_BUS];
    logic [N_BUS-1:0]  w_valid;
    logic [N_BUS-1:0]  w_acc;
    logic [N_BUS-1:0]  w_ent;
    logic [DATA_W-1:0] w_rf    [N_REG];
    logic              w_done;
    logic              w_wr_active;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_sel;
    logic              w_issue;

    // Dispatch decode; on a same-entry collision instbus1 wins.
    always_comb begin
        w_inst[0] = inst_t'(instbus1);
        w_inst[1] = inst_t'(instbus2);
        for (int b = 0; b < N_BUS; b++) begin
            w_valid[b] = (w_inst[b].opcode == OP_STORE) &&
                         ((w_inst[b].unit == TAG_ST0) || (w_inst[b].unit == TAG_ST1));
            w_ent[b]   = w_inst[b].unit[0];
        end
        w_acc[0] = w_valid[0] && (r_state[w_ent[0]] == S_EMPTY);
        w_acc[1] = w_valid[1] && (r_state[w_ent[1]] == S_EMPTY) &&
                   !(w_valid[0] && (w_ent[0] == w_ent[1]));
        for (int r = 0; r < N_REG; r++) begin
            w_rf[r] = regfile[r*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_done      = r_mem_wr_en && mem_ready;
        w_wr_active = ((r_state[0] == S_WRITE) || (r_state[1] == S_WRITE)) && !w_done;
        w_rdy0      = (r_state[0] == S_READY);
        w_rdy1      = (r_state[1] == S_READY);
        w_sel       = (w_rdy0 && w_rdy1) ? r_older : w_rdy1;
        w_issue     = !w_wr_active && (w_rdy0 || w_rdy1);
    end

    // Next-state for both entries and the memory port.
    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            w_state_nx[i] = r_state[i];
            w_addr_nx[i]  = r_addr[i];
            w_data_nx[i]  = r_data[i];
            w_tag_nx[i]   = r_tag[i];
        end
        w_older_nx     = r_older;
        w_mem_wr_en_nx = r_mem_wr_en;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_data_nx  = r_mem_data;
        w_err_nx       = (w_valid[0] && !w_acc[0]) || (w_valid[1] && !w_acc[1]);

        for (int i = 0; i < N_ENT; i++) begin
            if ((r_state[i] == S_WRITE) && w_done) begin
                w_state_nx[i] = S_EMPTY;
            end
            if ((r_state[i] == S_WAIT) && cdb_valid && (cdb[39:32] == r_tag[i])) begin
                w_state_nx[i] = S_READY;
                w_data_nx[i]  = cdb[31:0];
            end
        end

        for (int b = 0; b < N_BUS; b++) begin
            if (w_acc[b]) begin
                w_addr_nx[w_ent[b]] = w_inst[b].addr;
                w_tag_nx[w_ent[b]]  = w_inst[b].src;
                if (w_inst[b].src[7:2] == REG_BASE) begin
                    w_data_nx[w_ent[b]]  = w_rf[w_inst[b].src[1:0]];
                    w_state_nx[w_ent[b]] = S_READY;
                end else if (cdb_valid && (cdb[39:32] == w_inst[b].src)) begin
                    w_data_nx[w_ent[b]]  = cdb[31:0];
                    w_state_nx[w_ent[b]] = S_READY;
                end else begin
                    w_state_nx[w_ent[b]] = S_WAIT;
                end
            end
        end

        // A lone dispatch is younger than whatever already sits in the other entry.
        if (w_acc[0] && w_acc[1]) begin
            w_older_nx = w_ent[0];
        end else if (w_acc[0]) begin
            w_older_nx = ~w_ent[0];
        end else if (w_acc[1]) begin
            w_older_nx = ~w_ent[1];
        end

        if (w_done) begin
            w_mem_wr_en_nx = 1'b0;
        end
        if (w_issue) begin
            w_state_nx[w_sel] = S_WRITE;
            w_mem_wr_en_nx    = 1'b1;
            w_mem_addr_nx     = r_addr[w_sel];
            w_mem_data_nx     = r_data[w_sel];
        end

        for (int i = 0; i < N_ENT; i++) begin
            w_busy_nx[i] = (w_state_nx[i] != S_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_state[i] <= S_EMPTY;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
                r_tag[i]   <= '0;
            end
            r_older     <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= '0;
            r_err       <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                r_state[i] <= w_state_nx[i];
                r_addr[i]  <= w_addr_nx[i];
                r_data[i]  <= w_data_nx[i];
                r_tag[i]   <= w_tag_nx[i];
            end
            r_older     <= w_older_nx;
            r_mem_wr_en <= w_mem_wr_en_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_data  <= w_mem_data_nx;
            r_busy      <= w_busy_nx;
            r_err       <= w_err_nx;
        end
    end

    assign mem_wr_en    = r_mem_wr_en;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign busy         = r_busy;
    assign dispatch_err = r_err;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: expected memory writes go into a queue that a
// monitor drains on every accepted write; stimulus also checks cycle-level timing.
module tb_store_unit;

    localparam logic [7:0] STORE = 8'h02;
    localparam logic [7:0] ST0   = 8'h50;
    localparam logic [7:0] ST1   = 8'h51;
    localparam logic [7:0] R0    = 8'h10;
    localparam logic [7:0] R1    = 8'h11;
    localparam logic [7:0] R2    = 8'h12;
    localparam logic [7:0] R3    = 8'h13;
    localparam logic [7:0] M0    = 8'h30;
    localparam logic [7:0] LD0   = 8'h40;
    localparam logic [7:0] LD1   = 8'h41;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [39:0]  instbus1;
    logic [39:0]  instbus2;
    logic [127:0] regfile;
    logic         cdb_valid;
    logic [39:0]  cdb;
    logic         mem_ready;
    logic         mem_wr_en;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_data;
    logic [1:0]   busy;
    logic         dispatch_err;

    int           n_vec = 0;
    int           n_err = 0;
    logic [47:0]  exp_q [$];
    logic [47:0]  exp_w;
    logic         stalled = 1'b0;
    logic [15:0]  st_addr;
    logic [31:0]  st_data;

    store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instbus1     (instbus1),
        .instbus2     (instbus2),
        .regfile      (regfile),
        .cdb_valid    (cdb_valid),
        .cdb          (cdb),
        .mem_ready    (mem_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .busy         (busy),
        .dispatch_err (dispatch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on each accepted write and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_hold", 64'({mem_wr_en, mem_addr, mem_data}), 64'({1'b1, st_addr, st_data}));
            end
            if (mem_wr_en && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("write", 64'({mem_addr, mem_data}), 64'(exp_w));
                end
            end
            stalled = mem_wr_en && !mem_ready;
            st_addr = mem_addr;
            st_data = mem_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; instbus1 = '0; instbus2 = '0; regfile = '0;
        cdb_valid = 1'b0; cdb = '0; mem_ready = 1'b1;
        nc(); nc();
        @(negedge clk);
        chk("rst_wr_en", 64'(mem_wr_en), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_data", 64'(mem_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(dispatch_err), 64'(0));
        nc();
        rst_n = 1'b1;
        nc();

        // Register operand: write two cycles after dispatch.
        regfile  = {32'h0, 32'h47bdce12, 32'h0, 32'h0};
        instbus1 = {ST0, STORE, 16'h0010, R2};
        exp_q.push_back({16'h0010, 32'h47bdce12});
        @(negedge clk); nc();
        instbus1 = '0;
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'(2'b01));
        chk("t1_early", 64'(mem_wr_en), 64'(0));
        nc();
        @(negedge clk);
        chk("t1_wr", 64'({mem_wr_en, mem_addr, mem_data}), 64'({1'b1, 16'h0010, 32'h47bdce12}));
        nc();
        @(negedge clk);
        chk("t1_done", 64'({mem_wr_en, busy}), 64'({1'b0, 2'b00}));
        nc();

        // Producer operand waits for the matching broadcast.
        instbus1 = {ST1, STORE, 16'h0020, LD0};
        exp_q.push_back({16'h0020, 32'h345612bc});
        @(negedge clk); nc();
        instbus1 = '0;
        @(negedge clk);
        chk("t2_busy_c1", 64'({busy, mem_wr_en}), 64'({2'b10, 1'b0}));
        nc();
        cdb_valid = 1'b1; cdb = {LD1, 32'hdeadbeef};
        @(negedge clk);
        chk("t2_busy_c2", 64'({busy, mem_wr_en}), 64'({2'b10, 1'b0}));
        nc();
        cdb = {LD0, 32'h345612bc};
        @(negedge clk);
        chk("t2_wait_c3", 64'({busy, mem_wr_en}), 64'({2'b10, 1'b0}));
        nc();
        cdb_valid = 1'b0; cdb = '0;
        @(negedge clk);
        chk("t2_ready_c4", 64'({busy, mem_wr_en}), 64'({2'b10, 1'b0}));
        nc();
        @(negedge clk);
        chk("t2_wr", 64'({mem_wr_en, mem_addr, mem_data}), 64'({1'b1, 16'h0020, 32'h345612bc}));
        nc();
        @(negedge clk);
        chk("t2_done", 64'({mem_wr_en, busy}), 64'({1'b0, 2'b00}));
        nc();

        // Dual dispatch: back-to-back writes in bus order.
        regfile  = {32'h0, 32'h0, 32'h22222222, 32'h11111111};
        instbus1 = {ST0, STORE, 16'h0001, R0};
        instbus2 = {ST1, STORE, 16'h0002, R1};
        exp_q.push_back({16'h0001, 32'h11111111});
        exp_q.push_back({16'h0002, 32'h22222222});
        @(negedge clk); nc();
        instbus1 = '0; instbus2 = '0;
        @(negedge clk);
        chk("t3_busy", 64'(busy), 64'(2'b11));
        nc();
        @(negedge clk);
        chk("t3_wr0", 64'({mem_wr_en, mem_addr}), 64'({1'b1, 16'h0001}));
        nc();
        @(negedge clk);
        chk("t3_wr1", 64'({mem_wr_en, mem_addr, mem_data, busy}), 64'({1'b1, 16'h0002, 32'h22222222, 2'b10}));
        nc();
        @(negedge clk);
        chk("t3_done", 64'({mem_wr_en, busy}), 64'({1'b0, 2'b00}));
        nc();

        // Memory backpressure for four cycles.
        regfile   = {32'ha5a5a5a5, 32'h0, 32'h0, 32'h0};
        instbus1  = {ST0, STORE, 16'h0030, R3};
        mem_ready = 1'b0;
        exp_q.push_back({16'h0030, 32'ha5a5a5a5});
        @(negedge clk); nc();
        instbus1 = '0;
        @(negedge clk); nc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_stall", 64'({mem_wr_en, mem_addr, mem_data}), 64'({1'b1, 16'h0030, 32'ha5a5a5a5}));
            nc();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t4_release", 64'(mem_wr_en), 64'(1));
        nc();
        @(negedge clk);
        chk("t4_done", 64'({mem_wr_en, busy}), 64'({1'b0, 2'b00}));
        nc();

        // Collisions, busy-entry dispatch and ignored words.
        regfile   = {32'h0, 32'h0, 32'h22222222, 32'h11111111};
        mem_ready = 1'b0;
        instbus1  = {ST0, STORE, 16'h0040, R0};
        instbus2  = {ST0, STORE, 16'h0044, R1};
        exp_q.push_back({16'h0040, 32'h11111111});
        @(negedge clk); nc();
        instbus1 = {ST0, STORE, 16'h0048, R2};
        instbus2 = '0;
        @(negedge clk);
        chk("t5_collide", 64'({dispatch_err, busy}), 64'({1'b1, 2'b01}));
        nc();
        instbus1 = {ST1, 8'h03, 16'h0050, R0};
        @(negedge clk);
        chk("t5_busy_err", 64'(dispatch_err), 64'(1));
        nc();
        instbus1 = {8'h52, STORE, 16'h0054, R0};
        @(negedge clk);
        chk("t5_nonstore", 64'({dispatch_err, busy}), 64'({1'b0, 2'b01}));
        nc();
        instbus1  = '0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t5_badunit", 64'({dispatch_err, busy, mem_addr}), 64'({1'b0, 2'b01, 16'h0040}));
        nc();
        @(negedge clk);
        chk("t5_done", 64'({mem_wr_en, busy}), 64'({1'b0, 2'b00}));
        nc();

        // Same-cycle broadcast bypass.
        instbus1  = {ST1, STORE, 16'h0060, M0};
        cdb_valid = 1'b1;
        cdb       = {M0, 32'h0badf00d};
        exp_q.push_back({16'h0060, 32'h0badf00d});
        @(negedge clk); nc();
        instbus1 = '0; cdb_valid = 1'b0; cdb = '0;
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'(2'b10));
        nc();
        @(negedge clk);
        chk("t6_wr", 64'({mem_wr_en, mem_addr, mem_data}), 64'({1'b1, 16'h0060, 32'h0badf00d}));
        nc();
        @(negedge clk);
        chk("t6_done", 64'(mem_wr_en), 64'(0));
        nc();

        // Reset during a stalled write abandons both entries.
        mem_ready = 1'b0;
        instbus1  = {ST0, STORE, 16'h0070, R0};
        instbus2  = {ST1, STORE, 16'h0074, R1};
        @(negedge clk); nc();
        instbus1 = '0; instbus2 = '0;
        @(negedge clk); nc();
        @(negedge clk);
        chk("t7_pending", 64'({mem_wr_en, mem_addr}), 64'({1'b1, 16'h0070}));
        nc();
        rst_n    = 1'b0;
        instbus1 = {ST1, STORE, 16'h0078, R2};
        @(negedge clk); nc();
        rst_n     = 1'b1;
        instbus1  = '0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t7_rst_out", 64'({mem_wr_en, mem_addr, mem_data, busy, dispatch_err}), 64'(0));
        nc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t7_no_retry", 64'({mem_wr_en, busy}), 64'(0));
            nc();
        end

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
